// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sequencer.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

    // True when at least one channel of a mask is enabled.
    function automatic logic any_enabled(input logic [N_CH-1:0] mask);
        return |mask;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_chan_next_find.sv
// Combinational finder for the lowest enabled channel above (or, with incl,
// at or above) a given index.
module chan_next_find
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             incl,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Scan from the top down so that the lowest qualifying channel wins last.
    always_comb begin
        logic hit_s;
        nxt   = cur;
        found = 1'b0;
        hit_s = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            hit_s = mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))));
            nxt   = hit_s ? SEL_W'(i) : nxt;
            found = found | hit_s;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer in front of the 4:1 mux: walks Sel through the enabled
// channels, waits SETTLE cycles per channel, captures Z into Word and offers
// the word through a Valid/Ready handshake.
// Optional build macro MUX_SCAN_CONT_EN: continuous mode, a new scan is
// launched on every handshake edge with the mask re-latched from En.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [N_CH-1:0]  En,
    input  logic             Z,
    output logic [SEL_W-1:0] Sel,
    output logic             Busy,
    output logic [N_CH-1:0]  Word,
    output logic             Valid,
    input  logic             Ready
);

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    // With no settle time each channel is a single SAMPLE cycle.
    localparam scan_state_e ST_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    scan_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N_CH-1:0]  mask_r;
    logic [SEL_W-1:0] sel_r;
    logic [N_CH-1:0]  word_r;
    logic             busy_r;
    logic             valid_r;

    logic [SEL_W-1:0] first_sel_s;
    logic             first_found_s;
    logic [SEL_W-1:0] next_sel_s;
    logic             next_found_s;
    logic             hs_s;
    logic             launch_s;

    // First channel of a new scan, taken straight from the live En.
    chan_next_find u_first (
        .mask  (En),
        .cur   ({SEL_W{1'b0}}),
        .incl  (1'b1),
        .nxt   (first_sel_s),
        .found (first_found_s)
    );

    // Next channel of the running scan, from the latched mask.
    chan_next_find u_next (
        .mask  (mask_r),
        .cur   (sel_r),
        .incl  (1'b0),
        .nxt   (next_sel_s),
        .found (next_found_s)
    );

    assign hs_s = (state_r == ST_DONE) && valid_r && Ready;

`ifdef MUX_SCAN_CONT_EN
    assign launch_s = ((state_r == ST_IDLE) && Start) || hs_s;
`else
    assign launch_s = (state_r == ST_IDLE) && Start;
`endif

    // Scan FSM with settle counter, channel select and snapshot register.
    // An empty mask passes through one SAMPLE cycle that writes nothing and
    // finds no channel, so Valid rises one edge after the launch edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            mask_r  <= {N_CH{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            word_r  <= {N_CH{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (launch_s) begin
            mask_r  <= En;
            word_r  <= {N_CH{1'b0}};
            valid_r <= 1'b0;
            if (any_enabled(En) && first_found_s) begin
                sel_r   <= first_sel_s;
                busy_r  <= 1'b1;
                cnt_r   <= SETTLE_C;
                state_r <= ST_FIRST;
            end else begin
                busy_r  <= 1'b0;
                state_r <= ST_SAMPLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SETTLE: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SAMPLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mask_r[sel_r]) begin
                        word_r[sel_r] <= Z;
                    end else begin
                        word_r <= word_r;
                    end
                    if (next_found_s) begin
                        sel_r   <= next_sel_s;
                        cnt_r   <= SETTLE_C;
                        state_r <= ST_FIRST;
                    end else begin
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (hs_s) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign Sel   = sel_r;
    assign Busy  = busy_r;
    assign Word  = word_r;
    assign Valid = valid_r;

endmodule
